// File: rtl/id_ex_stage_if.sv
// Decode/writeback-side inputs and ALU-side outputs of the ID/EX stage.
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]   imm;
  logic              use_imm;
  logic [3:0]        alu_ctrl_in;
  logic              reg_write_in;
  logic              stall;
  logic              flush;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic [XLEN-1:0]   in1;
  logic [XLEN-1:0]   in2;
  logic [3:0]        alu_ctrl;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_valid;

  modport master (
    output in_valid, rs1_addr, rs2_addr, rd_addr, imm, use_imm, alu_ctrl_in,
           reg_write_in, stall, flush, wb_en, wb_addr, wb_data,
    input  in1, in2, alu_ctrl, ex_rs2_data, ex_rd, ex_reg_write, ex_valid
  );

  modport slave (
    input  in_valid, rs1_addr, rs2_addr, rd_addr, imm, use_imm, alu_ctrl_in,
           reg_write_in, stall, flush, wb_en, wb_addr, wb_data,
    output in1, in2, alu_ctrl, ex_rs2_data, ex_rd, ex_reg_write, ex_valid
  );
endinterface

// File: rtl/id_ex_stage.sv
// Operand fetch (regfile with write-through bypass) and ID/EX register; 1-cycle latency.
// Stall holds the register, flush or in_valid=0 inserts a bubble; writeback never stalls.
module id_ex_stage #(
  parameter int         XLEN        = 32,
  parameter int         ADDR_W      = 5,
  parameter logic [3:0] BUBBLE_CTRL = 4'b0000
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [ADDR_W-1:0] rd;
    logic [3:0]        ctrl;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   store;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, rd: '0,
                                    ctrl: BUBBLE_CTRL, op1: '0, op2: '0, store: '0};

  logic [XLEN-1:0] rf [NREG];
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  idex_t           q;
  idex_t           q_next;

  // x0 is never written, so its entry stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != '0) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    rs1_data = rf[bus.rs1_addr];
    if (bus.rs1_addr == '0)
      rs1_data = '0;
    else if (bus.wb_en && bus.wb_addr == bus.rs1_addr)
      rs1_data = bus.wb_data;
  end

  always_comb begin
    rs2_data = rf[bus.rs2_addr];
    if (bus.rs2_addr == '0)
      rs2_data = '0;
    else if (bus.wb_en && bus.wb_addr == bus.rs2_addr)
      rs2_data = bus.wb_data;
  end

  always_comb begin
    q_next = q;
    if (bus.flush) begin
      q_next = IDEX_BUBBLE;
    end else if (bus.stall) begin
      q_next = q;
    end else if (!bus.in_valid) begin
      q_next = IDEX_BUBBLE;
    end else begin
      q_next.valid     = 1'b1;
      q_next.reg_write = bus.reg_write_in;
      q_next.rd        = bus.rd_addr;
      q_next.ctrl      = bus.alu_ctrl_in;
      q_next.op1       = rs1_data;
      q_next.op2       = bus.use_imm ? bus.imm : rs2_data;
      q_next.store     = rs2_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q <= IDEX_BUBBLE;
    else     q <= q_next;
  end

  assign bus.in1          = q.op1;
  assign bus.in2          = q.op2;
  assign bus.alu_ctrl     = q.ctrl;
  assign bus.ex_rs2_data  = q.store;
  assign bus.ex_rd        = q.rd;
  assign bus.ex_reg_write = q.reg_write;
  assign bus.ex_valid     = q.valid;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Operand-fetch stage and ID/EX pipeline register directly upstream of the ALU. It holds the 32-entry integer register file with a single writeback port, reads two source registers, selects register or immediate for the second operand, and registers the ALU inputs (`in1`, `in2`, `alu_ctrl`) plus execute-stage control for one-cycle delivery to the ALU. It also supports stall, flush and bubble insertion so the hazard logic can steer the pipeline.

## Interface
Parameters:
- `XLEN`, 32, data and operand width.
- `ADDR_W`, 5, register address width; register count is 2^ADDR_W.
- `BUBBLE_CTRL`, 4'b0000, `alu_ctrl` value driven for a bubble or reset.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: decode presents a valid instruction this cycle.
- `rs1_addr` in ADDR_W: source register 1.
- `rs2_addr` in ADDR_W: source register 2.
- `rd_addr` in ADDR_W: destination register.
- `imm` in XLEN: sign-extended immediate from decode.
- `use_imm` in 1: 1 selects `imm` for `in2`.
- `alu_ctrl_in` in 4: ALU operation code, passed through unchanged.
- `reg_write_in` in 1: instruction writes `rd`.
- `stall` in 1: hold the ID/EX register.
- `flush` in 1: replace the ID/EX contents with a bubble.
- `wb_en` in 1: writeback enable.
- `wb_addr` in ADDR_W: writeback register.
- `wb_data` in XLEN: writeback data.
- `in1` out XLEN: ALU operand 1.
- `in2` out XLEN: ALU operand 2.
- `alu_ctrl` out 4: ALU operation.
- `ex_rs2_data` out XLEN: raw rs2 value, used as store data.
- `ex_rd` out ADDR_W: destination register for the execute stage.
- `ex_reg_write` out 1: the execute-stage instruction writes `rd`.
- `ex_valid` out 1: the execute-stage slot holds a real instruction.

## Operation
- **Register file.** 2^ADDR_W x XLEN.
  - Writes are synchronous: when `wb_en` is 1 and `wb_addr` is non-zero, `wb_data` is written on the rising edge.
  - A write to x0 is discarded.
- **Reads.** Combinational.
  - Address 0 always reads 0.
  - Write-through bypass: if `wb_en` is 1, `wb_addr` equals the read address and the read address is non-zero, the read returns `wb_data` in the same cycle.
- **Operand select.**
  - `in2` next = `use_imm` ? `imm` : rs2 read.
  - `in1` next = rs1 read.
  - `ex_rs2_data` next = rs2 read, regardless of `use_imm`.
- **ID/EX update priority** (per rising edge):
  1. `rst`
  2. `flush`
  3. `stall`
  4. `in_valid` = 0 (bubble)
  5. load
- **Bubble.**
  - `ex_valid` = 0, `ex_reg_write` = 0, `ex_rd` = 0.
  - `in1` = `in2` = `ex_rs2_data` = 0.
  - `alu_ctrl` = BUBBLE_CTRL.
- **Load.**
  - `ex_valid` = 1.
  - All other ID/EX fields capture the operand-select results and the decode inputs.
- **Stall.**
  - Every ID/EX output holds its value.
  - Register-file writeback still completes.
  - Decode must hold its inputs during the stall; the re-read after the stall sees any writeback that landed during it.
- **Flush with stall.** Flush wins and inserts a bubble.
- **Reset.**
  - Every register-file entry is cleared to 0.
  - The ID/EX register is set to the bubble values.
  - `wb_en` is ignored in any cycle where `rst` is 1.
- **Arithmetic.** None; all data passes through at XLEN width unmodified.

## Timing
- Latency is 1 cycle: decode inputs at edge N appear on the ALU-side outputs after edge N.
- Writeback written at edge N is visible to a same-cycle read (via bypass) and to all later reads (from the array).
- Reset value of every output is 0, except `alu_ctrl`, which resets to BUBBLE_CTRL.
- Reset asserted mid-stream clears everything on the next edge; the first valid load is possible on the edge after `rst` deasserts.
- No combinational path from inputs to outputs; all outputs come straight from flops.

## Test plan
- **Reset.** Hold `rst` for 2 cycles, then read rs1 = 3 and rs2 = 31 with `in_valid` = 1.
  - During reset: all outputs 0 and `alu_ctrl` = 0000.
  - After the load: `in1` = 0, `in2` = 0, `ex_valid` = 1.
- **Basic load.** Write x5 = 32'h5 and x6 = 32'h6, then issue rs1 = 5, rs2 = 6, `alu_ctrl_in` = 0010, rd = 9, `reg_write_in` = 1.
  - Next cycle: `in1` = 5, `in2` = 6, `alu_ctrl` = 0010, `ex_rd` = 9, `ex_reg_write` = 1, `ex_valid` = 1.
- **Bypass and x0.**
  - Same-cycle writeback x7 = 32'hDEADBEEF while reading rs1 = 7: next cycle `in1` = 32'hDEADBEEF.
  - Writeback x0 = 32'hFFFFFFFF, then read rs1 = 0: `in1` = 0.
- **Immediate.** x6 = 6, rs2 = 6, `use_imm` = 1, `imm` = 32'hFFFFF800.
  - Next cycle: `in2` = 32'hFFFFF800 and `ex_rs2_data` = 6.
- **Stall and flush.**
  - After a load, assert `stall` for 3 cycles while writing back x5 = 32'hA: outputs are held unchanged for all 3 cycles.
  - Release the stall with rs1 = 5: `in1` = 32'hA.
  - Assert `stall` and `flush` together: next cycle is a bubble (`ex_valid` = 0, all operands 0).
  - Drive `in_valid` = 0: a bubble is inserted.
- **Reset mid-operation.** After writing x10 = 32'h1234 and loading a valid instruction, assert `rst` for 1 cycle together with `wb_en` (x11 = 32'h55).
  - Outputs return to bubble values.
  - Reading x10 and x11 afterwards returns 0 for both.
